// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter that merges NUM_REQ valid/ready requesters
//   into one FIFO write port. A requester keeps its grant for a burst of
//   up to MAX_BURST beats. The burst ends early when the granted requester
//   drops valid. A full FIFO stalls the burst without ending it.
//   Exactly one IDLE arbitration cycle separates consecutive bursts.
//
// Ports
//   clk        : sole clock, also the FIFO write clock
//   reset      : asynchronous, active-high
//   req_valid  : per-requester data valid            [NUM_REQ]
//   req_data   : requester i data at [i*DATA_W +: DATA_W]
//   req_ready  : per-requester accept (combinational)  [NUM_REQ]
//   full       : FIFO full flag, clk domain
//   wr_enable  : FIFO write strobe
//   wr_data    : FIFO write data, zero when wr_enable is low
//   grant      : registered one-hot grant, zero when no grant is held
//   busy       : high while a burst is in progress
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        full,
    output logic                        wr_enable,
    output logic [DATA_W-1:0]           wr_data,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy
);

    localparam int PTR_W  = (NUM_REQ   > 1) ? $clog2(NUM_REQ)   : 1;
    localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]          r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [PTR_W-1:0]    r_gidx;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [BEAT_W-1:0]   r_beat_cnt;

    logic                w_burst;
    logic                w_gvalid;
    logic                w_sel_found;
    logic [PTR_W-1:0]    w_sel_idx;
    logic [PTR_W:0]      w_scan;
    logic [PTR_W-1:0]    w_next_ptr;

    // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
    // w_scan is one bit wider so rr_ptr + k never overflows before the wrap.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_scan      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_scan >= (PTR_W+1)'(NUM_REQ)) begin
                w_scan = w_scan - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_sel_found && req_valid[w_scan[PTR_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_scan[PTR_W-1:0];
            end
        end
    end

    assign w_next_ptr = (r_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);

    assign w_burst   = (r_state == S_BURST);
    assign w_gvalid  = req_valid[r_gidx];

    assign busy      = w_burst;
    assign grant     = r_grant;
    assign req_ready = (w_burst && !full) ? r_grant : '0;
    assign wr_enable = w_burst & w_gvalid & ~full;
    assign wr_data   = wr_enable ? req_data[r_gidx*DATA_W +: DATA_W] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel_found) begin
                        r_grant    <= NUM_REQ'(1) << w_sel_idx;
                        r_gidx     <= w_sel_idx;
                        r_beat_cnt <= '0;
                        r_state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    // full only stalls; the burst ends on its last beat or
                    // when the granted requester stops offering data.
                    if (!full) begin
                        if (w_gvalid && (r_beat_cnt != LAST_BEAT)) begin
                            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        end else begin
                            r_state  <= S_IDLE;
                            r_grant  <= '0;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        full;
    logic        wr_enable;
    logic [7:0]  wr_data;
    logic [3:0]  grant;
    logic        busy;

    logic [3:0]  m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_ready;
    logic        m_full;
    logic        m_wen;
    logic [7:0]  m_wdata;
    logic [3:0]  m_grant;
    logic        m_busy;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) u4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .full(full), .wr_enable(wr_enable),
        .wr_data(wr_data), .grant(grant), .busy(busy)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(1)) u1 (
        .clk(clk), .reset(reset), .req_valid(m_valid), .req_data(m_data),
        .req_ready(m_ready), .full(m_full), .wr_enable(m_wen),
        .wr_data(m_wdata), .grant(m_grant), .busy(m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_sent  = 0;
    int          n_wr    = 0;
    int          wr_per_req [4];
    logic [5:0]  seq     [4];
    logic [5:0]  exp_seq [4];
    logic [7:0]  sent_q  [$];
    logic [7:0]  fifo_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Each requester presents {id, seq}; seq advances only when accepted.
    task automatic drive_data();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = {2'(i), seq[i]};
    endtask

    task automatic monitor();
        logic [1:0] id;
        logic [7:0] e;
        chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (full) chk("no_write_when_full", 32'(wr_enable), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                sent_q.push_back({2'(i), seq[i]});
                n_sent++;
            end
        end
        if (wr_enable) begin
            id = wr_data[7:6];
            chk("write_from_granted", 32'(grant[id]), 32'd1);
            if (sent_q.size() == 0) begin
                chk("scoreboard_underflow", 32'(sent_q.size()), 32'd1);
            end else begin
                e = sent_q.pop_front();
                chk("scoreboard_data", 32'(wr_data), 32'(e));
            end
            chk("per_req_order", 32'(wr_data[5:0]), 32'(exp_seq[id]));
            exp_seq[id] = wr_data[5:0] + 6'd1;
            n_wr++;
            wr_per_req[id]++;
            fifo_log.push_back(wr_data);
        end else begin
            chk("wr_data_idle_zero", 32'(wr_data), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) seq[i] = seq[i] + 6'd1;
        end
    endtask

    task automatic cycle();
        #1;
        monitor();
        @(posedge clk);
        @(negedge clk);
        drive_data();
    endtask

    task automatic pulse_reset();
        req_valid = 4'h0;
        full      = 1'b0;
        reset     = 1'b1;
        cycle();
        reset     = 1'b0;
    endtask

    initial begin
        int w0;
        int r0;
        logic [5:0] s0;
        logic [3:0] eg;

        reset     = 1'b1;
        req_valid = 4'hF;
        full      = 1'b0;
        m_valid   = 4'h0;
        m_full    = 1'b0;
        m_data    = 32'hD3_00_00_D0;
        for (int i = 0; i < 4; i++) begin
            seq[i] = 6'd0; exp_seq[i] = 6'd0; wr_per_req[i] = 0;
        end
        drive_data();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_grant",     32'(grant),     32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_wr_enable", 32'(wr_enable), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_wr_data",   32'(wr_data),   32'd0);
        reset = 1'b0;

        // All four requesters streaming: 4-beat bursts 0,1,2,3 with one gap.
        w0 = n_wr;
        for (int c = 0; c < 20; c++) begin
            #1;
            eg = (c % 5 == 0) ? 4'h0 : 4'(1 << ((c / 5) % 4));
            chk("rr_grant",     32'(grant),     32'(eg));
            chk("rr_wr_enable", 32'(wr_enable), 32'(c % 5 != 0));
            cycle();
        end
        chk("rr_writes_per_20", 32'(n_wr - w0), 32'd16);
        #1;
        chk("rr_gap_after_3", 32'(grant), 32'd0);
        cycle();
        #1;
        chk("rr_wrap_to_0", 32'(grant), 32'h1);
        pulse_reset();

        // Requester 2 alone, two words, then drops valid.
        req_valid = 4'b0100;
        r0 = wr_per_req[2];
        cycle();
        #1;
        chk("early_grant", 32'(grant), 32'h4);
        cycle();
        cycle();
        req_valid = 4'b0000;
        #1;
        chk("early_grant_held", 32'(grant),     32'h4);
        chk("early_no_write",   32'(wr_enable), 32'd0);
        cycle();
        #1;
        chk("early_grant_clear", 32'(grant), 32'd0);
        chk("early_writes",      32'(wr_per_req[2] - r0), 32'd2);
        req_valid = 4'b1001;
        cycle();
        #1;
        chk("early_rr_ptr_3", 32'(grant), 32'h8);
        pulse_reset();

        // Requester 1 burst, full for 5 cycles at beat 1.
        req_valid = 4'b0010;
        r0 = wr_per_req[1];
        cycle();
        #1;
        chk("stall_beat0", 32'(wr_enable), 32'd1);
        cycle();
        full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_wr_enable", 32'(wr_enable), 32'd0);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_grant",     32'(grant),     32'h2);
            chk("stall_busy",      32'(busy),      32'd1);
            cycle();
        end
        full = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_resume", 32'(wr_enable), 32'd1);
            cycle();
        end
        req_valid = 4'b0000;
        #1;
        chk("stall_done_grant", 32'(grant), 32'd0);
        chk("stall_beats",      32'(wr_per_req[1] - r0), 32'd4);
        pulse_reset();

        // Reset during beat 2 of requester 2's burst.
        req_valid = 4'b0100;
        s0 = seq[2];
        cycle();
        cycle();
        cycle();
        #1;
        chk("midrst_beat2_active", 32'(wr_enable), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_wr_enable", 32'(wr_enable), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_grant",     32'(grant),     32'd0);
        chk("midrst_wr_data",   32'(wr_data),   32'd0);
        chk("midrst_log_a", 32'(fifo_log[fifo_log.size()-2]), 32'({2'd2, s0}));
        chk("midrst_log_b", 32'(fifo_log[fifo_log.size()-1]), 32'({2'd2, s0 + 6'd1}));
        req_valid = 4'b1110;
        cycle();
        reset = 1'b0;
        cycle();
        #1;
        chk("midrst_first_grant", 32'(grant), 32'h2);
        for (int c = 0; c < 12; c++) cycle();
        chk("midrst_resend", 32'(exp_seq[2]), 32'(s0 + 6'd6));
        req_valid = 4'b0000;
        cycle();
        cycle();

        // Random valid/full soak.
        for (int c = 0; c < 10000; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            full      = ($urandom_range(0, 3) == 0);
            cycle();
        end
        req_valid = 4'b0000;
        full      = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        chk("soak_queue_empty", 32'(sent_q.size()), 32'd0);
        chk("soak_sent_eq_written", 32'(n_sent), 32'(n_wr));

        // Single-beat bursts: requesters 0 and 3 alternate.
        m_valid = 4'b1001;
        for (int c = 0; c < 8; c++) begin
            #1;
            eg = (c % 2 == 0) ? 4'h0 : ((c % 4 == 1) ? 4'h1 : 4'h8);
            chk("mb1_grant",     32'(m_grant), 32'(eg));
            chk("mb1_ready",     32'(m_ready), 32'(eg));
            chk("mb1_busy",      32'(m_busy),  32'(c % 2));
            chk("mb1_wr_enable", 32'(m_wen),   32'(c % 2));
            chk("mb1_wr_data",   32'(m_wdata),
                32'((c % 4 == 1) ? 8'hD0 : (c % 4 == 3) ? 8'hD3 : 8'h00));
            cycle();
        end
        m_valid = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
